// File: rtl/l2_fill_responder.sv
// L2 fill responder: queues L1 instruction-cache line-fill requests, looks each up in a
// direct-mapped L2 tag store and answers in order after a hit- or miss-dependent latency.
module l2_fill_responder #(
    parameter int DEPTH    = 4,
    parameter int SETS     = 64,
    parameter int HIT_LAT  = 2,
    parameter int MISS_LAT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [25:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    output logic [25:0] resp_addr,
    output logic        resp_hit,
    input  logic        resp_ready,
    output logic [31:0] hits,
    output logic [31:0] misses,
    output logic [31:0] reqs
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // The requester holds req_valid/req_addr until accepted; resp_valid/resp_addr/resp_hit
    // stay stable until an edge with resp_ready=1. Neither ready depends on its own valid.

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = 20;
    localparam int MAX_LAT = (MISS_LAT > HIT_LAT) ? MISS_LAT : HIT_LAT;
    localparam int WAIT_W  = $clog2(MAX_LAT) + 1;

    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [WAIT_W-1:0] HIT_LOAD   = WAIT_W'(HIT_LAT - 1);
    localparam logic [WAIT_W-1:0] MISS_LOAD  = WAIT_W'(MISS_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // FSM state is kept in a typed signal so checkers can bind to it directly.
    state_t state;
    state_t next_state;

    logic [25:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;

    logic [25:0]       cur_addr;
    logic              cur_hit;
    logic [WAIT_W-1:0] wait_cnt;
    logic [SETS-1:0]   valid_bits;
    logic [TAG_W-1:0]  tag_mem [SETS];
    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic              lookup_hit;

    // Request FIFO. Ready is forced low while reset is asserted.
    assign fifo_nonempty = (count != '0);
    assign req_ready     = !rst && (count < FULL_COUNT);
    assign push          = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Tag lookup for the request currently held in LOOKUP.
    assign cur_idx    = cur_addr[IDX_W-1:0];
    assign cur_tag    = cur_addr[25:6];
    assign lookup_hit = valid_bits[cur_idx] && (tag_mem[cur_idx] == cur_tag);

    always_ff @(posedge clk) begin
        if (state == S_LOOKUP && !lookup_hit) begin
            tag_mem[cur_idx] <= cur_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr   <= '0;
            cur_hit    <= 1'b0;
            wait_cnt   <= '0;
            valid_bits <= '0;
            hits       <= '0;
            misses     <= '0;
            reqs       <= '0;
        end else begin
            if (push) begin
                reqs <= reqs + 32'd1;
            end
            if (pop) begin
                cur_addr <= fifo_mem[rd_ptr];
            end
            if (state == S_LOOKUP) begin
                if (lookup_hit) begin
                    hits     <= hits + 32'd1;
                    cur_hit  <= 1'b1;
                    wait_cnt <= HIT_LOAD;
                end else begin
                    misses              <= misses + 32'd1;
                    cur_hit             <= 1'b0;
                    wait_cnt            <= MISS_LOAD;
                    valid_bits[cur_idx] <= 1'b1;
                end
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WAIT_ONE;
            end
            // Flush is last so it overrides an install made in the same cycle.
            if (flush) begin
                valid_bits <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (fifo_nonempty) next_state = S_LOOKUP;
            S_LOOKUP: next_state = S_WAIT;
            S_WAIT:   if (wait_cnt == '0) next_state = S_RESP;
            S_RESP:   if (resp_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE:  pop = fifo_nonempty;
            S_RESP:  resp_valid = 1'b1;
            default: begin
                pop        = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    assign resp_addr = cur_addr;
    assign resp_hit  = cur_hit;

endmodule

// File: doc/l2_fill_responder.md
L2_FILL_RESPONDER -- requirements
Module: l2_fill_responder

Interface
REQ-001 Parameter DEPTH, default 4: request FIFO entries (power of 2, 2..16).
REQ-002 Parameter SETS, default 64: direct-mapped L2 tag sets (index = req_addr[5:0]).
REQ-003 Parameter HIT_LAT, default 2: WAIT cycles on hit (>=1).
REQ-004 Parameter MISS_LAT, default 10: WAIT cycles on miss (>=1).
REQ-005 The block SHALL use a single clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  line-fill request from the L1 instruction cache.
- req_addr  in  26  line address (byte address [31:6]); tag = [25:6], index = [5:0].
- req_ready  out  1  FIFO can accept this cycle.
- flush  in  1  one-cycle pulse: clear all L2 valid bits.
- resp_valid  out  1  fill response available.
- resp_addr  out  26  line address of the response.
- resp_hit  out  1  1 = served from L2, 0 = served from memory.
- resp_ready  in  1  requester consumes the response.
- hits  out  32  L2 hit count.
- misses  out  32  L2 miss count.
- reqs  out  32  accepted request count.

Function
REQ-006 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; reqs increments by 1 at that edge.
REQ-007 req_ready SHALL be 1 exactly when the FIFO holds fewer than DEPTH entries; there is no push at full, and a request offered while full is held by the requester, not dropped.
REQ-008 The FIFO SHALL preserve order; responses return in acceptance order.
REQ-009 The FSM SHALL have four states: IDLE, LOOKUP, WAIT, RESP.
REQ-010 IDLE: if the FIFO is non-empty, pop the head into the current-request register and go to LOOKUP; otherwise stay in IDLE.
REQ-011 LOOKUP (one cycle): hit = valid[index] && tag[index]==req tag.
- On hit: hits+1, wait counter = HIT_LAT-1.
- On miss: misses+1, wait counter = MISS_LAT-1, install tag and set valid.
- Go to WAIT.
REQ-012 WAIT: decrement the counter each cycle; when the counter is 0, go to RESP.
REQ-013 RESP: resp_valid=1, and resp_addr/resp_hit are stable until an edge with resp_ready=1. At that edge go to IDLE, and resp_valid is 0 the next cycle.
REQ-014 A push and a pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-015 Latency, FIFO empty and FSM in IDLE at acceptance, resp_ready held 1: resp_valid SHALL rise after edge LAT+2 counted from the acceptance edge (hit 4, miss 12 with defaults).
REQ-016 flush SHALL clear all valid bits at that edge, and SHALL win over a LOOKUP install in the same cycle. An in-flight request completes with its already-decided resp_hit.
REQ-017 Counters SHALL wrap modulo 2^32 with no saturation.
REQ-018 Invariant: hits+misses SHALL equal the number of LOOKUP cycles, which is always <= reqs.
REQ-019 The FIFO, counters and tag store SHALL use no combinational path from req_valid to req_ready or from resp_ready to resp_valid.

Reset
REQ-020 While rst=1 the block SHALL hold these values, applied asynchronously:
- FSM in IDLE, FIFO empty.
- All valid bits 0.
- hits/misses/reqs = 0.
- resp_valid=0, resp_addr=0, resp_hit=0.
- req_ready=0.
REQ-021 In the first cycle after rst deasserts, req_ready=1.
REQ-022 Reset mid-operation SHALL discard the in-flight request and all queued requests with no response.

Verification
REQ-023 Cold miss: after reset, req_addr=26'h0000041 for 1 cycle, resp_ready=1 -> resp_valid high 12 edges later, resp_addr=26'h0000041, resp_hit=0; misses=1, reqs=1.
REQ-024 Re-hit: repeat 26'h0000041 -> response 4 edges after acceptance, resp_hit=1, hits=1.
REQ-025 Conflict: 26'h0000041 then 26'h0000081 (same index 1), then 26'h0000041 -> resp_hit = 0,0,0; misses=3 after a fresh reset.
REQ-026 Backpressure: resp_ready=0, issue 6 back-to-back requests.
- req_ready=1 for the first 5 accepts (4 in the FIFO plus 1 popped to LOOKUP), then 0.
- Releasing resp_ready drains all 6 in order.
REQ-027 Flush: hit 26'h0000041, pulse flush, request again -> resp_hit=0.
REQ-028 Reset mid-WAIT: assert rst during a miss WAIT.
- No resp_valid.
- Counters read 0.
- req_ready=1 one cycle after release.
